// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and handshake bundle between the PC sequencer and its environment
interface pc_sequencer_if #(parameter int OFF_W = 9);
    logic              start;
    logic              abort;
    logic [15:0]       pc_in;
    logic              mem_ack;
    logic              br_req;
    logic              br_taken;
    logic [OFF_W-1:0]  br_offset;
    logic              pc_reset;
    logic              jump_flag;
    logic [15:0]       next;
    logic              fetch_req;
    logic              busy;
    logic              halted;
    logic [15:0]       instr_count;

    modport slave (
        input  start, abort, pc_in, mem_ack, br_req, br_taken, br_offset,
        output pc_reset, jump_flag, next, fetch_req, busy, halted, instr_count
    );

    modport master (
        output start, abort, pc_in, mem_ack, br_req, br_taken, br_offset,
        input  pc_reset, jump_flag, next, fetch_req, busy, halted, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer that steers an external PC register and counts retired instructions
module pc_sequencer #(
    parameter int LAST_ADDR = 27,
    parameter int OFF_W     = 9
) (
    input logic          clk,
    input logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic signed [16:0] LAST_S = 17'(LAST_ADDR);

    state_t             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic               taken;
    logic signed [16:0] off_ext;
    logic signed [16:0] sum;
    logic [15:0]        target;

    assign taken   = bus.br_req & bus.br_taken;
    assign off_ext = {{(17 - OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
    assign sum     = $signed({1'b0, bus.pc_in}) + off_ext;
    assign target  = sum < 0 ? 16'd0 : sum > LAST_S ? 16'(LAST_ADDR) : sum[15:0];

    // next state and retired-instruction count; abort wins over everything and freezes the count
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (bus.abort) state_d = IDLE;
        else case (state_q)
            IDLE: if (bus.start) begin
                state_d = FETCH;
                count_d = '0;
            end
            FETCH: if (bus.mem_ack) state_d = EXEC;
            EXEC: begin
                state_d = (bus.pc_in == 16'(LAST_ADDR) && !taken) ? HALT : FETCH;
                count_d = count_q + 16'd1;
            end
            HALT: if (bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // PC control is Mealy on the branch inputs; status flags decode the state alone
    always_comb begin
        bus.pc_reset  = state_q == IDLE;
        bus.fetch_req = state_q == FETCH;
        bus.jump_flag = state_q == FETCH || state_q == HALT || (state_q == EXEC && taken);
        bus.next      = (state_q == FETCH || state_q == HALT) ? bus.pc_in :
                        (state_q == EXEC && taken) ? target : 16'd0;
        bus.busy      = state_q == FETCH || state_q == EXEC;
        bus.halted    = state_q == HALT;
    end

    assign bus.instr_count = count_q;

    // state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed runs with an EXEC-trace scoreboard around a modelled PC register
module tb_pc_sequencer;
    localparam int LAST = 27;
    localparam int OW   = 9;

    typedef struct packed {
        logic [15:0] pc;
        logic        jmp;
        logic [15:0] nxt;
    } exec_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [15:0] pc;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_exec = 0;
    int          exp_n;
    bit          sb_on = 0;
    exec_t       sb[$];
    exec_t       mon_e;

    bit                   br_en[LAST+1];
    bit                   br_tk[LAST+1];
    logic signed [OW-1:0] br_off[LAST+1];
    bit                   br_used[LAST+1];
    int                   stall_pc = -1;
    int                   stall_left = 0;

    pc_sequencer_if #(.OFF_W(OW)) bus();

    pc_sequencer #(.LAST_ADDR(LAST), .OFF_W(OW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.pc_in = pc;

    // PC register that the sequencer drives
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 16'd0;
        else if (bus.pc_reset) pc <= 16'd0;
        else if (bus.jump_flag) pc <= bus.next;
        else if (pc != 16'(LAST)) pc <= pc + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every EXEC cycle retires one scoreboard entry
    always @(negedge clk) begin
        #2;
        if (sb_on && rst_n && bus.busy && !bus.fetch_req) begin
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("exec_pc", pc, mon_e.pc);
                chk("exec_jump", bus.jump_flag, mon_e.jmp);
                chk("exec_next", bus.next, mon_e.nxt);
            end
            n_exec++;
        end
    end

    task automatic clear_tables();
        for (int i = 0; i <= LAST; i++) begin
            br_en[i] = 0;
            br_tk[i] = 0;
            br_off[i] = '0;
        end
        stall_pc = -1;
        stall_left = 0;
    endtask

    task automatic build_model(input int abort_at);
        int  p = 0;
        bit  used[LAST+1];
        bit  tk;
        int  t;
        sb.delete();
        for (int i = 0; i <= LAST; i++) used[i] = 0;
        for (int k = 0; k < 300; k++) begin
            tk = br_en[p] && br_tk[p] && !used[p];
            t = p + int'(br_off[p]);
            t = t < 0 ? 0 : (t > LAST ? LAST : t);
            sb.push_back('{pc: 16'(p), jmp: tk, nxt: tk ? 16'(t) : 16'd0});
            if (p == abort_at) break;
            if (tk) begin
                used[p] = 1;
                p = t;
            end else if (p == LAST) break;
            else p++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1;
    endtask

    task automatic run(input int abort_at);
        int cyc = 0;
        bit done = 0;
        int ip;
        for (int i = 0; i <= LAST; i++) br_used[i] = 0;
        n_exec = 0;
        sb_on = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            ip = int'(pc);
            bus.start = 0;
            bus.abort = 0;
            bus.mem_ack = !(ip == stall_pc && stall_left > 0);
            bus.br_req = ip <= LAST ? br_en[ip] : 1'b0;
            bus.br_taken = ip <= LAST ? (br_tk[ip] && !br_used[ip]) : 1'b0;
            bus.br_offset = ip <= LAST ? br_off[ip] : '0;
            #1;
            if (bus.halted) done = 1;
            else if (bus.fetch_req) begin
                chk("fetch_count", bus.instr_count, 32'(n_exec));
                chk("fetch_next", bus.next, pc);
                if (!bus.mem_ack) stall_left--;
            end else if (bus.busy) begin
                if (bus.br_req && bus.br_taken) br_used[ip] = 1;
                if (ip == abort_at) begin
                    bus.abort = 1;
                    done = 1;
                end
            end
        end
        chk("run_done", done, 1);
        @(negedge clk);
        sb_on = 0;
        bus.abort = 0;
        bus.mem_ack = 0;
        bus.br_req = 0;
        bus.br_taken = 0;
        #1;
    endtask

    task automatic leave_halt();
        @(negedge clk);
        bus.start = 1;
        #1;
        chk("halt_start_halted", bus.halted, 1);
        @(negedge clk);
        bus.start = 0;
        #1;
        chk("unhalt_pc_reset", bus.pc_reset, 1);
        chk("unhalt_halted", bus.halted, 0);
        chk("unhalt_count_held", bus.instr_count, 32'(exp_n));
        @(negedge clk);
        #1;
        chk("unhalt_pc_zero", pc, 0);
    endtask

    initial begin
        bus.start = 0;
        bus.abort = 0;
        bus.mem_ack = 0;
        bus.br_req = 0;
        bus.br_taken = 0;
        bus.br_offset = '0;
        clear_tables();
        #23;
        chk("rst_pc_reset", bus.pc_reset, 1);
        chk("rst_jump", bus.jump_flag, 0);
        chk("rst_next", bus.next, 0);
        chk("rst_fetch", bus.fetch_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_count", bus.instr_count, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_wait_busy", bus.busy, 0);
        chk("idle_wait_pc_reset", bus.pc_reset, 1);

        build_model(-1);
        exp_n = sb.size();
        pulse_start();
        run(-1);
        chk("runA_halted", bus.halted, 1);
        chk("runA_count", bus.instr_count, 28);
        chk("runA_pc", pc, LAST);
        chk("runA_halt_jump", bus.jump_flag, 1);
        chk("runA_halt_next", bus.next, LAST);
        chk("runA_sb_empty", sb.size(), 0);
        leave_halt();

        br_en[2] = 1;  br_tk[2] = 1;  br_off[2] = -9'sd256;
        br_en[5] = 1;  br_tk[5] = 0;  br_off[5] = 9'sd3;
        br_en[10] = 1; br_tk[10] = 1; br_off[10] = -9'sd3;
        br_en[20] = 1; br_tk[20] = 1; br_off[20] = 9'sd100;
        stall_pc = 4;
        stall_left = 5;
        build_model(-1);
        exp_n = sb.size();
        pulse_start();
        run(-1);
        chk("runB_halted", bus.halted, 1);
        chk("runB_count", bus.instr_count, 32'(exp_n));
        chk("runB_pc", pc, LAST);
        chk("runB_stall_done", stall_left, 0);
        chk("runB_sb_empty", sb.size(), 0);
        leave_halt();

        clear_tables();
        build_model(12);
        pulse_start();
        run(12);
        chk("abort_busy", bus.busy, 0);
        chk("abort_pc_reset", bus.pc_reset, 1);
        chk("abort_count", bus.instr_count, 12);
        chk("abort_sb_empty", sb.size(), 0);
        @(negedge clk);
        #1;
        chk("abort_pc_zero", pc, 0);
        chk("abort_count_held", bus.instr_count, 12);

        pulse_start();
        bus.mem_ack = 0;
        @(negedge clk);
        bus.start = 0;
        #1;
        chk("areset_in_fetch", bus.fetch_req, 1);
        #2;
        rst_n = 0;
        #1;
        chk("areset_pc_reset", bus.pc_reset, 1);
        chk("areset_jump", bus.jump_flag, 0);
        chk("areset_next", bus.next, 0);
        chk("areset_fetch", bus.fetch_req, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_count", bus.instr_count, 0);
        #4;
        rst_n = 1;
        bus.mem_ack = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("areset_stay_idle", bus.busy, 0);
        chk("areset_count_after", bus.instr_count, 0);
        chk("areset_pc", pc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter LAST_ADDR, default 27, shall be the final program address (the PC saturation/halt point).
REQ-002 Parameter OFF_W, default 9, shall be the branch offset width (two's complement).
REQ-003 clk  input  1  sole clock; all state shall update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin run (IDLE) / re-arm after halt (HALT).
REQ-006 abort  input  1  synchronous return to IDLE from any state; start is ignored in a cycle where abort is high.
REQ-007 pc_in  input  16  current PC value fed back from the PC register.
REQ-008 mem_ack  input  1  instruction fetch complete; sampled only in FETCH.
REQ-009 br_req  input  1  decoded instruction is a branch; sampled only in EXEC.
REQ-010 br_taken  input  1  branch condition true; sampled only in EXEC.
REQ-011 br_offset  input  OFF_W  signed PC-relative branch offset.
REQ-012 pc_reset  output  1  synchronous clear request to the PC register.
REQ-013 jump_flag  output  1  load request to the PC register (load value = next).
REQ-014 next  output  16  PC load value.
REQ-015 fetch_req  output  1  instruction fetch request.
REQ-016 busy  output  1  high in FETCH or EXEC.
REQ-017 halted  output  1  high in HALT.
REQ-018 instr_count  output  16  count of retired instructions.

Function
REQ-019 FSM states shall be IDLE, FETCH, EXEC and HALT, with state held in a registered encoding.
REQ-020 PC register semantics: each clk edge, pc_reset clears PC to 0; else jump_flag loads next; else PC increments, saturating at LAST_ADDR.
REQ-021 IDLE: pc_reset=1, jump_flag=0, next=0, fetch_req=0; start=1 -> FETCH and instr_count cleared to 0.
REQ-022 FETCH: fetch_req=1, jump_flag=1, next=pc_in (PC holds); mem_ack=1 -> EXEC, else stay in FETCH.
REQ-023 EXEC: fetch_req=0; exactly one cycle; instr_count increments by 1 (wraps 0xFFFF->0).
REQ-024 EXEC with br_req & br_taken: jump_flag=1, next=target; otherwise jump_flag=0 (PC self-increments).
REQ-025 target = pc_in + sign-extended br_offset, computed at 17-bit signed; result <0 -> 0; result >LAST_ADDR -> LAST_ADDR.
REQ-026 EXEC exit: pc_in==LAST_ADDR and branch not taken -> HALT; all other cases -> FETCH (a taken branch at LAST_ADDR continues).
REQ-027 HALT: jump_flag=1, next=pc_in, fetch_req=0, halted=1; start=1 -> IDLE (PC cleared on the next edge); instr_count held.
REQ-028 abort=1 in any state -> IDLE on the next edge; outputs in that cycle follow the current state; instr_count held.
REQ-029 pc_reset, jump_flag, next and fetch_req shall be combinational from the state and the EXEC/FETCH inputs (Mealy); busy and halted shall be decoded from the state only.
REQ-030 When jump_flag=0, next shall be 0.
REQ-031 br_req=1 with br_taken=0 shall be treated as not taken; br_taken with br_req=0 shall be ignored.

Reset
REQ-032 rst_n low shall immediately force IDLE, instr_count=0, and outputs pc_reset=1, jump_flag=0, next=0, fetch_req=0, busy=0, halted=0.
REQ-033 Reset asserted mid-FETCH or mid-EXEC shall abandon the instruction without incrementing instr_count.
REQ-034 After rst_n deasserts, the block shall stay in IDLE until start=1 is sampled.

Verification
REQ-035 Run: reset, start, mem_ack=1 every FETCH, no branches -> PC steps 0,1,...,27 (each value for 2 cycles); HALT reached with instr_count=28, halted=1.
REQ-036 Fetch stall: mem_ack low 5 cycles at pc=4 -> pc_in stays 4, fetch_req=1 throughout, instr_count unchanged until ack.
REQ-037 Branches: at pc=10, offset -3 taken -> pc 7; at pc=20, offset +100 taken -> pc 27; at pc=2, offset -256 -> pc 0.
REQ-038 Not-taken branch at pc=5 (br_req=1, br_taken=0) -> pc 6, jump_flag=0 in EXEC.
REQ-039 abort in EXEC at pc=12 -> IDLE, pc_reset=1, pc 0 next edge, instr_count held; start in HALT -> IDLE, then start -> new run with instr_count=0.
REQ-040 Async reset pulse mid-FETCH (not clock-aligned) -> outputs take reset values without waiting for a clk edge; no spurious instr_count increment.
